// File: rtl/wr_ptr_full.sv
// Write-side pointer, full/almost-full/level and sticky overflow logic of an async FIFO.
// Latency: mem_we/wr_addr combinational; pointer, flags and level registered (1 cycle).
// Backpressure: writes are dropped while wr_full is high and recorded in wr_overflow.
module wr_ptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  input  logic                  ovf_clr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDR_WIDTH:0] wr_ptr_bin;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] full_match;
  logic                ovf_set;

  assign mem_we    = wr_en & ~wr_full;
  assign wr_addr   = wr_ptr_bin[ADDR_WIDTH-1:0];
  assign bin_next  = wr_ptr_bin + {{ADDR_WIDTH{1'b0}}, mem_we};
  assign gray_next = bin_next ^ (bin_next >> 1);

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(rd_ptr_gray_sync >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer by exactly one wrap.
  assign full_match = {~rd_ptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                       rd_ptr_gray_sync[ADDR_WIDTH-2:0]};
  assign level_next = bin_next - rd_bin;
  assign ovf_set    = wr_en & wr_full;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_bin     <= '0;
      wr_ptr_gray    <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level       <= '0;
      wr_overflow    <= 1'b0;
    end else begin
      wr_ptr_bin     <= bin_next;
      wr_ptr_gray    <= gray_next;
      wr_full        <= (gray_next == full_match);
      wr_almost_full <= (level_next >= AFULL_THRESH);
      wr_level       <= level_next;
      if (ovf_set) begin
        wr_overflow <= 1'b1;
      end else if (ovf_clr) begin
        wr_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wr_ptr_full.sv
// Directed bench for wr_ptr_full: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wr_ptr_full;

  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          wr_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [PW-1:0] rd_ptr_gray_sync = '0;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_ptr_gray;
  logic          wr_full;
  logic          wr_almost_full;
  logic [PW-1:0] wr_level;
  logic          wr_overflow;

  wr_ptr_full #(.ADDR_WIDTH(AW), .AFULL_MARGIN(2)) dut (
    .wr_clk           (wr_clk),
    .rst_n            (rst_n),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .ovf_clr          (ovf_clr),
    .mem_we           (mem_we),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .wr_full          (wr_full),
    .wr_almost_full   (wr_almost_full),
    .wr_level         (wr_level),
    .wr_overflow      (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [2:0]    ph;
    logic [7:0]    idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [PW-1:0] gray;
    logic          full;
    logic          afull;
    logic [PW-1:0] lvl;
    logic          ovf;
    logic          onebit;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          e;
  logic [PW-1:0] prev_gray = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [PW-1:0] g(input int v);
    logic [PW-1:0] b;
    b = PW'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t mk(input int ph, input int idx, input bit we, input int addr,
                              input logic [PW-1:0] gr, input bit full, input bit afull,
                              input int lvl, input bit ovf, input bit onebit);
    exp_t r;
    r.ph     = 3'(ph);
    r.idx    = 8'(idx);
    r.we     = we;
    r.addr   = AW'(addr);
    r.gray   = gr;
    r.full   = full;
    r.afull  = afull;
    r.lvl    = PW'(lvl);
    r.ovf    = ovf;
    r.onebit = onebit;
    return r;
  endfunction

  task automatic chk(input string nm, input int ph, input int idx, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s [phase %0d step %0d]: got %0d, expected %0d", nm, ph, idx, act, exp_v);
    end
  endtask

  task automatic step(input logic rn, input logic en, input logic clr,
                      input logic [PW-1:0] rd, input exp_t ex);
    @(posedge wr_clk);
    #1;
    rst_n            = rn;
    wr_en            = en;
    ovf_clr          = clr;
    rd_ptr_gray_sync = rd;
    sb_q.push_back(ex);
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge wr_clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("mem_we",         int'(e.ph), int'(e.idx), int'(mem_we),         int'(e.we));
      chk("wr_addr",        int'(e.ph), int'(e.idx), int'(wr_addr),        int'(e.addr));
      chk("wr_ptr_gray",    int'(e.ph), int'(e.idx), int'(wr_ptr_gray),    int'(e.gray));
      chk("wr_full",        int'(e.ph), int'(e.idx), int'(wr_full),        int'(e.full));
      chk("wr_almost_full", int'(e.ph), int'(e.idx), int'(wr_almost_full), int'(e.afull));
      chk("wr_level",       int'(e.ph), int'(e.idx), int'(wr_level),       int'(e.lvl));
      chk("wr_overflow",    int'(e.ph), int'(e.idx), int'(wr_overflow),    int'(e.ovf));
      if (e.onebit) begin
        chk("gray_one_bit_step", int'(e.ph), int'(e.idx),
            int'($countones(wr_ptr_gray ^ prev_gray) <= 1), 1);
      end
    end
    prev_gray = wr_ptr_gray;
  end

  initial begin
    int n;
    int p;
    int rdv;

    // Phase 0: reset state; mem_we follows wr_en while held in reset.
    step(1'b0, 1'b0, 1'b0, '0, mk(0, 0, 0, 0, '0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b0, '0, mk(0, 1, 1, 0, '0, 0, 0, 0, 0, 0));

    // Phase 1: 20 cycles of writes against an idle reader; 16 accepted, then full.
    for (int i = 0; i < 20; i++) begin
      n = (i < 16) ? i : 16;
      step(1'b1, 1'b1, 1'b0, '0,
           mk(1, i, i < 16, (i < 16) ? i : 0, g(n), i >= 16, n >= 14, n, i >= 17, 0));
    end

    // Phase 2: sticky overflow clear, re-set, and set-wins-over-clear.
    step(1'b1, 1'b0, 1'b1, '0, mk(2, 0, 0, 0, g(16), 1, 1, 16, 1, 0));
    step(1'b1, 1'b0, 1'b0, '0, mk(2, 1, 0, 0, g(16), 1, 1, 16, 0, 0));
    step(1'b1, 1'b1, 1'b0, '0, mk(2, 2, 0, 0, g(16), 1, 1, 16, 0, 0));
    step(1'b1, 1'b1, 1'b1, '0, mk(2, 3, 0, 0, g(16), 1, 1, 16, 1, 0));
    step(1'b1, 1'b0, 1'b0, '0, mk(2, 4, 0, 0, g(16), 1, 1, 16, 1, 0));
    step(1'b1, 1'b0, 1'b1, '0, mk(2, 5, 0, 0, g(16), 1, 1, 16, 1, 0));
    step(1'b1, 1'b0, 1'b0, '0, mk(2, 6, 0, 0, g(16), 1, 1, 16, 0, 0));

    // Phase 3: reader advances to 4 (gray 00110); 4 more writes, full again.
    step(1'b1, 1'b0, 1'b0, 5'b00110, mk(3, 0, 0, 0, g(16), 1, 1, 16, 0, 0));
    step(1'b1, 1'b1, 1'b0, 5'b00110, mk(3, 1, 1, 0, g(16), 0, 0, 12, 0, 0));
    step(1'b1, 1'b1, 1'b0, 5'b00110, mk(3, 2, 1, 1, g(17), 0, 0, 13, 0, 0));
    step(1'b1, 1'b1, 1'b0, 5'b00110, mk(3, 3, 1, 2, g(18), 0, 1, 14, 0, 0));
    step(1'b1, 1'b1, 1'b0, 5'b00110, mk(3, 4, 1, 3, g(19), 0, 1, 15, 0, 0));
    // Reader catches up fully to 20 here, so the FIFO drains to empty next edge.
    step(1'b1, 1'b0, 1'b0, g(20),    mk(3, 5, 0, 4, g(20), 1, 1, 16, 0, 0));

    // Phase 4: 100 continuous writes, reader trails the writer by two cycles.
    // Write pointer during cycle k is 20+k; level settles at 3; wraps 31->0 at k=12.
    for (int k = 0; k < 100; k++) begin
      p   = 20 + k;
      rdv = (18 + k < 20) ? 20 : 18 + k;
      n   = (k < 3) ? k : 3;
      step(1'b1, 1'b1, 1'b0, g(rdv), mk(4, k, 1, p % 16, g(p), 0, 0, n, 0, 1));
    end

    // Phase 5: fresh start, burst to level 9, then reset mid-burst.
    step(1'b0, 1'b0, 1'b0, '0, mk(5, 0, 0, 0, '0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, mk(5, 1 + i, 1, i, g(i), 0, 0, i, 0, 0));
    end
    step(1'b1, 1'b0, 1'b0, '0, mk(5, 10, 0, 9, g(9), 0, 0, 9, 0, 0));
    step(1'b0, 1'b1, 1'b0, '0, mk(5, 11, 1, 0, '0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, '0, mk(5, 12, 1, 0, '0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, '0, mk(5, 13, 1, 1, g(1), 0, 0, 1, 0, 0));

    @(negedge wr_clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
